// File: rtl/memory_stage.sv
// Memory pipeline stage: word-addressed data RAM with load/store, out-of-range
// detection, and the M->W pipeline register bank with stall hold.
module memory_stage #(
    parameter int unsigned DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        regWriteM,
    input  logic        memWriteM,
    input  logic [1:0]  resultSrcM,
    input  logic [15:0] aluResM,
    input  logic [15:0] writeDataM,
    input  logic [15:0] PCPlus2M,
    input  logic [3:0]  RdM,
    input  logic        stallM,
    output logic        regWriteW,
    output logic [1:0]  resultSrcW,
    output logic [15:0] aluResW,
    output logic [15:0] readDataW,
    output logic [15:0] PCPlus2W,
    output logic [3:0]  RdW,
    output logic        addrErrW
);

    localparam int unsigned AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [16:0] BYTE_LIMIT = 17'(2 * DEPTH);
    localparam logic [1:0]  SRC_LOAD   = 2'b01;

    logic [15:0]   ram [DEPTH];
    logic [AW-1:0] word_idx;
    logic          in_range;
    logic          mem_access;
    logic          store_en;
    logic [15:0]   load_data;

    always_comb begin
        word_idx   = aluResM[AW:1];
        in_range   = ({1'b0, aluResM} < BYTE_LIMIT);
        mem_access = memWriteM || (resultSrcM == SRC_LOAD);
        store_en   = rst && memWriteM && !stallM && in_range;
        load_data  = '0;
        if (in_range) begin
            load_data = ram[word_idx];
        end
    end

    // RAM is deliberately not reset; rst gates the write enable so an
    // edge seen while reset is held cannot commit a store.
    always_ff @(posedge clk) begin
        if (store_en) begin
            ram[word_idx] <= writeDataM;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regWriteW  <= 1'b0;
            resultSrcW <= '0;
            aluResW    <= '0;
            readDataW  <= '0;
            PCPlus2W   <= '0;
            RdW        <= '0;
            addrErrW   <= 1'b0;
        end else if (!stallM) begin
            regWriteW  <= regWriteM;
            resultSrcW <= resultSrcM;
            aluResW    <= aluResM;
            readDataW  <= load_data;
            PCPlus2W   <= PCPlus2M;
            RdW        <= RdM;
            if (mem_access && !in_range) begin
                addrErrW <= 1'b1;
            end
        end
    end

endmodule
